// File: rtl/dat_mem_bulk_if.sv
// dat_mem_bulk_if: host store/read port and bulk-loader handshake of the data memory
interface dat_mem_bulk_if #(
    parameter int W         = 8,
    parameter int AW        = 8,
    parameter int NUM_WORDS = 15
);
    logic                              write_en;
    logic [AW-1:0]                     waddr;
    logic [W-1:0]                      data_in;
    logic [AW-1:0]                     raddr;
    logic [W-1:0]                      data_out;
    logic                              load_start;
    logic [NUM_WORDS-1:0][2*W-1:0]     load_data;
    logic                              load_busy;
    logic                              load_done;

    modport master (
        output write_en, waddr, data_in, raddr, load_start, load_data,
        input  data_out, load_busy, load_done
    );
    modport slave (
        input  write_en, waddr, data_in, raddr, load_start, load_data,
        output data_out, load_busy, load_done
    );
endinterface

// File: rtl/dat_mem_bulk.sv
// dat_mem_bulk: byte memory with one host write port, one read port of selectable latency,
// and a loader that copies a codeword image into a fixed window, low byte first.
module dat_mem_bulk #(
    parameter int W          = 8,
    parameter int BYTE_COUNT = 256,
    parameter int NUM_WORDS  = 15,
    parameter int LOAD_BASE  = 64,
    parameter int RD_LATENCY = 0
) (
    input logic           clk,
    input logic           rst_n,
    dat_mem_bulk_if.slave bus
);
    localparam int AW = $clog2(BYTE_COUNT);
    localparam int NB = 2 * NUM_WORDS;
    localparam int IW = $clog2(NB + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    if (LOAD_BASE + NB > BYTE_COUNT) begin : g_bad_window
        $error("dat_mem_bulk: load window exceeds BYTE_COUNT");
    end
    if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_latency
        $error("dat_mem_bulk: RD_LATENCY must be 0 or 1");
    end

    state_t                        state_q, state_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [NUM_WORDS-1:0][2*W-1:0] image_q, image_d;
    logic [W-1:0]                  core_q [BYTE_COUNT];
    logic                          ld_we;
    logic [2*W-1:0]                ld_word;
    logic [W-1:0]                  ld_byte;
    logic [W-1:0]                  rd_data;
    logic [AW-1:0]                 ld_addr;
    logic                          wr_ok;
    logic                          rd_ok;

    assign ld_word = image_q[idx_q[IW-1:1]];
    assign ld_byte = idx_q[0] ? ld_word[2*W-1:W] : ld_word[W-1:0];
    assign ld_addr = AW'(LOAD_BASE) + AW'(idx_q);
    // Non-power-of-2 sizes leave a hole at the top of the address space
    assign wr_ok = {1'b0, bus.waddr} < (AW+1)'(BYTE_COUNT);
    assign rd_ok = {1'b0, bus.raddr} < (AW+1)'(BYTE_COUNT);
    assign rd_data = rd_ok ? core_q[bus.raddr] : '0;
    assign bus.load_busy = state_q == LOAD;
    assign bus.load_done = state_q == DONE;

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        image_d = image_q;
        ld_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                    idx_d = '0;
                    image_d = bus.load_data;
                end
            end
            LOAD: begin
                if (!bus.write_en) begin
                    ld_we = 1'b1;
                    idx_d = idx_q + 1'b1;
                    state_d = (idx_q == IW'(NB - 1)) ? DONE : LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q <= '0;
            image_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            image_q <= image_d;
        end
    end

    // The host wins any cycle it writes; the loader only writes while stalled-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BYTE_COUNT; i++) core_q[i] <= '0;
        end else if (bus.write_en && wr_ok) begin
            core_q[bus.waddr] <= bus.data_in;
        end else if (ld_we) begin
            core_q[ld_addr] <= ld_byte;
        end
    end

    if (RD_LATENCY == 0) begin : g_rd_comb
        assign bus.data_out = rd_data;
    end else begin : g_rd_reg
        logic [W-1:0] dout_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dout_q <= '0;
            else dout_q <= rd_data;
        end
        assign bus.data_out = dout_q;
    end
endmodule

// File: tb/tb_dat_mem_bulk.sv
// tb_dat_mem_bulk: directed checks of the combinational-read instance against a queue-based
// memory/loader model, plus literal checks on a registered-read, 200-entry instance.
module tb_dat_mem_bulk;
    localparam int NW = 15;
    localparam int LB = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dat_mem_bulk_if #(.W(8), .AW(8), .NUM_WORDS(NW)) bA ();
    dat_mem_bulk_if #(.W(8), .AW(8), .NUM_WORDS(NW)) bB ();

    dat_mem_bulk #(.W(8), .BYTE_COUNT(256), .NUM_WORDS(NW), .LOAD_BASE(LB), .RD_LATENCY(0))
        u_a (.clk(clk), .rst_n(rst_n), .bus(bA.slave));
    dat_mem_bulk #(.W(8), .BYTE_COUNT(200), .NUM_WORDS(NW), .LOAD_BASE(LB), .RD_LATENCY(1))
        u_b (.clk(clk), .rst_n(rst_n), .bus(bB.slave));

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;
    int busy_cnt = 0;
    int done_cnt = 0;

    logic [7:0] mem_m [256];
    logic [7:0] lq [$];
    int lpos = 0;
    bit done_m = 1'b0;
    bit idle_m;
    bit dn_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input int a, input logic [7:0] exp, input string nm);
        bA.raddr = 8'(a);
        #1;
        chk(nm, bA.data_out, exp);
    endtask

    task automatic pulse_start;
        bA.load_start = 1'b1;
        tick;
        bA.load_start = 1'b0;
    endtask

    task automatic wait_done;
        for (int k = 0; k < 200 && done_cnt == 0; k++) tick;
        chk("done_seen", done_cnt != 0, 1);
    endtask

    // Model: memory array plus a queue of loader bytes still to be written
    initial begin
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                foreach (mem_m[i]) mem_m[i] = 8'h00;
                lq.delete();
                done_m = 1'b0;
            end else begin
                idle_m = lq.size() == 0 && !done_m;
                dn_m = 1'b0;
                if (bA.write_en) begin
                    mem_m[bA.waddr] = bA.data_in;
                end else if (lq.size() > 0) begin
                    mem_m[LB + lpos] = lq.pop_front();
                    lpos++;
                    dn_m = lq.size() == 0;
                end
                if (idle_m && bA.load_start) begin
                    lpos = 0;
                    for (int i = 0; i < 2 * NW; i++)
                        lq.push_back(i % 2 ? bA.load_data[i/2][15:8] : bA.load_data[i/2][7:0]);
                end
                done_m = dn_m;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("model_dout", bA.data_out, mem_m[bA.raddr]);
                chk("model_busy", bA.load_busy, lq.size() != 0);
                chk("model_done", bA.load_done, done_m);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bA.load_busy) busy_cnt++;
            if (bA.load_done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bA.write_en = 0; bA.waddr = 0; bA.data_in = 0; bA.raddr = 0;
        bA.load_start = 0; bA.load_data = '0;
        bB.write_en = 0; bB.waddr = 0; bB.data_in = 0; bB.raddr = 0;
        bB.load_start = 0; bB.load_data = '0;
        #1 rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        chk_on = 1'b1;
        // Reset after arbitrary writes clears everything
        bA.write_en = 1; bA.waddr = 5; bA.data_in = 8'h11; tick;
        bA.waddr = 64; bA.data_in = 8'h22; tick;
        bA.waddr = 200; bA.data_in = 8'h33; tick;
        bA.write_en = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", bA.load_busy, 0);
        chk("rst_done", bA.load_done, 0);
        chk("rst_b_dout", bB.data_out, 0);
        for (int a = 0; a < 256; a++) rd_a(a, 8'h00, "rst_read");
        tick;
        rst_n = 1'b1;
        tick;
        // Combinational read sees the write only after the edge
        bA.write_en = 1; bA.waddr = 3; bA.data_in = 8'hA5; bA.raddr = 3;
        #1 chk("rd0_same_cycle", bA.data_out, 8'h00);
        tick;
        bA.write_en = 0;
        #1 chk("rd0_next_cycle", bA.data_out, 8'hA5);
        // Plain load, window neighbours untouched
        bA.write_en = 1; bA.waddr = 63; bA.data_in = 8'h11; tick;
        bA.waddr = 94; bA.data_in = 8'h22; tick;
        bA.write_en = 0;
        for (int i = 0; i < NW; i++) bA.load_data[i] = {8'(8'h80 + i), 8'(i)};
        busy_cnt = 0; done_cnt = 0;
        pulse_start;
        wait_done;
        tick; tick;
        chk("load_busy_len", busy_cnt, 30);
        chk("load_done_cnt", done_cnt, 1);
        for (int i = 0; i < NW; i++) begin
            rd_a(LB + 2 * i, 8'(i), "load_lo");
            rd_a(LB + 2 * i + 1, 8'(8'h80 + i), "load_hi");
        end
        rd_a(63, 8'h11, "below_window");
        rd_a(94, 8'h22, "above_window");
        rd_a(64, 8'h00, "pin_64");
        rd_a(93, 8'h8E, "pin_93");
        // Load with three host-write stalls and load_data scrambled after acceptance
        for (int i = 0; i < NW; i++) bA.load_data[i] = {8'(8'hC0 + i), 8'(8'h40 + i)};
        busy_cnt = 0; done_cnt = 0;
        pulse_start;
        bA.load_data = '1;
        repeat (5) tick;
        bA.write_en = 1; bA.waddr = 10; bA.data_in = 8'h5A;
        repeat (3) tick;
        bA.write_en = 0;
        wait_done;
        tick; tick;
        chk("stall_busy_len", busy_cnt, 33);
        chk("stall_done_cnt", done_cnt, 1);
        rd_a(10, 8'h5A, "stall_host_byte");
        for (int i = 0; i < NW; i++) begin
            rd_a(LB + 2 * i, 8'(8'h40 + i), "stall_lo");
            rd_a(LB + 2 * i + 1, 8'(8'hC0 + i), "stall_hi");
        end
        // Reset after ten loader bytes aborts the load
        for (int i = 0; i < NW; i++) bA.load_data[i] = {8'(8'h80 + i), 8'(i)};
        busy_cnt = 0; done_cnt = 0;
        pulse_start;
        repeat (10) tick;
        rst_n = 1'b0;
        #1 chk("abort_busy", bA.load_busy, 0);
        tick;
        rst_n = 1'b1;
        repeat (40) tick;
        chk("abort_no_done", done_cnt, 0);
        rd_a(64, 8'h00, "abort_win_64");
        rd_a(73, 8'h00, "abort_win_73");
        // A second start while busy is dropped
        busy_cnt = 0; done_cnt = 0;
        pulse_start;
        repeat (3) tick;
        pulse_start;
        wait_done;
        repeat (40) tick;
        chk("ignore_done_cnt", done_cnt, 1);
        chk("ignore_busy_len", busy_cnt, 30);
        // Registered read: read-before-write, then out-of-range on the 200-entry instance
        bB.write_en = 1; bB.waddr = 7; bB.data_in = 8'h11; bB.raddr = 7;
        tick;
        bB.data_in = 8'h3C;
        #1 chk("rd1_before_old", bB.data_out, 8'h00);
        tick;
        bB.write_en = 0;
        #1 chk("rd1_same_edge", bB.data_out, 8'h11);
        tick;
        chk("rd1_next_edge", bB.data_out, 8'h3C);
        bB.write_en = 1; bB.waddr = 199; bB.data_in = 8'h77; tick;
        bB.waddr = 250; bB.data_in = 8'hFF; tick;
        bB.write_en = 0; bB.raddr = 199; tick;
        chk("rd1_last_entry", bB.data_out, 8'h77);
        bB.raddr = 250; tick;
        chk("rd1_out_of_range", bB.data_out, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
